// File: rtl/seq_window_gen_pkg.sv
`default_nettype none
// ============================================================================
// seq_window_gen_pkg
// Shared window width default and fill-state encoding for seq_window_gen.
// Rev 1.0 - initial release
// ============================================================================
package seq_window_gen_pkg;

   localparam int SEQ_W = 4;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FILL  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_window_gen_shreg.sv
`default_nettype none
// ============================================================================
// seq_window_gen_shreg
// W-bit shift register; newest bit enters at bit 0.
// Rev 1.0 - initial release
// ============================================================================
module seq_window_gen_shreg #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic         din,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= {r_q[W-2:0], din};
      end
   end

   assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/seq_window_gen.sv
`default_nettype none
// ============================================================================
// seq_window_gen
// Serial-to-parallel sliding-window builder with valid/ready on both sides.
// Rev 1.0 - initial release
// ============================================================================
module seq_window_gen
   import seq_window_gen_pkg::*;
#(
   parameter int W     = SEQ_W,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_bit,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W-1:0]     out_win,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] fill
);

   localparam logic [CNT_W-1:0] C_FILL_MAX = CNT_W'(W);

   state_t           r_state;
   logic [CNT_W-1:0] r_fill;
   logic             r_out_valid;
   logic             w_in_ready;
   logic             w_acc;
   logic [W-1:0]     w_win;

   // Bubble-free: a full window being consumed frees the slot in the same cycle.
   assign w_in_ready = !rst && !clr &&
                       ((r_state != ST_FULL) || !r_out_valid || out_ready);
   assign w_acc      = in_valid && w_in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_EMPTY;
         r_fill      <= '0;
         r_out_valid <= 1'b0;
      end else if (clr) begin
         r_state     <= ST_EMPTY;
         r_fill      <= '0;
         r_out_valid <= 1'b0;
      end else if (w_acc) begin
         case (r_state)
            ST_EMPTY: r_state <= ST_FILL;
            ST_FILL:  r_state <= (r_fill == C_FILL_MAX - 1'b1) ? ST_FULL : ST_FILL;
            ST_FULL:  r_state <= ST_FULL;
            default:  r_state <= ST_EMPTY;
         endcase
         r_fill      <= (r_fill == C_FILL_MAX) ? r_fill : r_fill + 1'b1;
         r_out_valid <= (r_fill >= C_FILL_MAX - 1'b1);
      end else if (out_ready && r_out_valid) begin
         r_out_valid <= 1'b0;
      end
   end

   seq_window_gen_shreg #(
      .W (W)
   ) u_shreg (
      .clk (clk),
      .rst (rst),
      .en  (w_acc),
      .clr (clr),
      .din (in_bit),
      .q   (w_win)
   );

   assign in_ready  = w_in_ready;
   assign out_win   = w_win;
   assign out_valid = r_out_valid;
   assign fill      = r_fill;

endmodule
`default_nettype wire
